// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: instruction width,
// bubble encoding, reset PC, PC stride and the per-edge fetch action decode.
package fetch_stage_pkg;

    localparam int unsigned INSTRUCTION_LEN = 32;
    localparam logic [INSTRUCTION_LEN-1:0] NOP_INSTR = 32'hE000_0000;
    localparam logic [INSTRUCTION_LEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [INSTRUCTION_LEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        FETCH_RESET,
        FETCH_REDIRECT,
        FETCH_HOLD,
        FETCH_ADVANCE
    } fetch_action_e;

    // Priority: reset, then taken branch (which overrides a stall), then stall.
    function automatic fetch_action_e fetch_action(
        input logic rst,
        input logic branch_taken,
        input logic freeze
    );
        if (rst) begin
            return FETCH_RESET;
        end else if (branch_taken) begin
            return FETCH_REDIRECT;
        end else if (freeze) begin
            return FETCH_HOLD;
        end else begin
            return FETCH_ADVANCE;
        end
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: synchronous reset or flush loads a bubble,
// freeze holds the current contents.
module if_id_register #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hE000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic [INSTR_W-1:0] instruction_in,
    input  logic               valid_in,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] instruction_out,
    output logic               valid_out
);

    logic [ADDR_W-1:0]  pc_d, pc_q;
    logic [INSTR_W-1:0] instruction_d, instruction_q;
    logic               valid_d, valid_q;

    always_comb begin
        pc_d          = pc_q;
        instruction_d = instruction_q;
        valid_d       = valid_q;
        if (rst || flush) begin
            pc_d          = '0;
            instruction_d = NOP_INSTR;
            valid_d       = 1'b0;
        end else if (!freeze) begin
            pc_d          = pc_in;
            instruction_d = instruction_in;
            valid_d       = valid_in;
        end
    end

    always_ff @(posedge clk) begin
        pc_q          <= pc_d;
        instruction_q <= instruction_d;
        valid_q       <= valid_d;
    end

    assign pc_out          = pc_q;
    assign instruction_out = instruction_q;
    assign valid_out       = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory read
// port and loads the IF/ID register; counts instructions passed to decode.
module fetch_stage #(
    parameter int unsigned ADDR_W    = fetch_stage_pkg::INSTRUCTION_LEN,
    parameter int unsigned INSTR_W   = fetch_stage_pkg::INSTRUCTION_LEN,
    parameter logic [ADDR_W-1:0]  RESET_PC  = fetch_stage_pkg::RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic [ADDR_W-1:0]  imem_address,
    output logic               imem_mem_read,
    output logic               imem_mem_write,
    output logic [INSTR_W-1:0] imem_write_data,
    input  logic [INSTR_W-1:0] imem_read_data,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] instruction_out,
    output logic               valid_out,
    output logic [31:0]        fetch_count
);

    import fetch_stage_pkg::*;

    fetch_action_e     action;
    logic [ADDR_W-1:0] pc_d, pc_q;
    logic [ADDR_W-1:0] pc_plus_step;
    logic [31:0]       fetch_count_d, fetch_count_q;

    assign action       = fetch_action(rst, branch_taken, freeze);
    assign pc_plus_step = pc_q + ADDR_W'(PC_STEP);

    always_comb begin
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        unique case (action)
            FETCH_RESET: begin
                pc_d          = RESET_PC;
                fetch_count_d = '0;
            end
            FETCH_REDIRECT: begin
                pc_d = {branch_addr[ADDR_W-1:2], 2'b00};
            end
            FETCH_HOLD: begin
            end
            FETCH_ADVANCE: begin
                pc_d          = pc_plus_step;
                fetch_count_d = fetch_count_q + 32'd1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        pc_q          <= pc_d;
        fetch_count_q <= fetch_count_d;
    end

    if_id_register #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .flush           (branch_taken),
        .pc_in           (pc_plus_step),
        .instruction_in  (imem_read_data),
        .valid_in        (1'b1),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    // Memory preloads while rst is high, so no read is issued then.
    assign imem_address    = pc_q;
    assign imem_mem_read   = ~rst;
    assign imem_mem_write  = 1'b0;
    assign imem_write_data = '0;
    assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural memory plus a reference
// model whose expected IF/ID state is queued per edge and checked after it.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_address;
    logic        imem_mem_read;
    logic        imem_mem_write;
    logic [31:0] imem_write_data;
    logic [31:0] imem_read_data;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;
    logic [31:0] fetch_count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifid_pc;
        logic [31:0] ifid_instr;
        logic        ifid_valid;
        logic [31:0] count;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_count = 32'h0;
    logic [31:0] m_ifpc  = 32'h0;
    logic [31:0] m_ifins = 32'hE000_0000;
    logic        m_ifv   = 1'b0;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem_address    (imem_address),
        .imem_mem_read   (imem_mem_read),
        .imem_mem_write  (imem_mem_write),
        .imem_write_data (imem_write_data),
        .imem_read_data  (imem_read_data),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'hE000_0000;
            32'h4:   return 32'hE3A0_0014;
            32'h8:   return 32'hE3A0_1A01;
            default: return 32'hE1A0_0000 ^ (a * 32'h9E37_79B9);
        endcase
    endfunction

    assign imem_read_data = mem_word(imem_address);

    // Advance the model by one edge using the current inputs, queue the
    // expected post-edge state, then clock the DUT and settle.
    task automatic tick();
        exp_t x;
        if (rst) begin
            m_pc = 32'h0; m_count = 32'h0;
            m_ifpc = 32'h0; m_ifins = 32'hE000_0000; m_ifv = 1'b0;
        end else if (branch_taken) begin
            m_pc = branch_addr & 32'hFFFF_FFFC;
            m_ifpc = 32'h0; m_ifins = 32'hE000_0000; m_ifv = 1'b0;
        end else if (!freeze) begin
            m_ifpc = m_pc + 32'd4; m_ifins = mem_word(m_pc); m_ifv = 1'b1;
            m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
        end
        x.pc = m_pc; x.ifid_pc = m_ifpc; x.ifid_instr = m_ifins;
        x.ifid_valid = m_ifv; x.count = m_count;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        #1;
        n_checks++;
        if (imem_mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read got=%b exp=0", imem_mem_read); end
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            n_checks++;
            if (imem_address !== e.pc || pc_out !== e.ifid_pc || instruction_out !== e.ifid_instr
                || valid_out !== e.ifid_valid || fetch_count !== e.count) begin
                n_fail++;
                $display("FAIL reset_state addr=%h pc=%h ins=%h v=%b cnt=%0d exp %h %h %h %b %0d",
                         imem_address, pc_out, instruction_out, valid_out, fetch_count,
                         e.pc, e.ifid_pc, e.ifid_instr, e.ifid_valid, e.count);
            end
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (imem_address !== 32'h0 || imem_mem_read !== 1'b1 || imem_mem_write !== 1'b0 || imem_write_data !== 32'h0) begin
            n_fail++;
            $display("FAIL post_reset_imem addr=%h rd=%b wr=%b wd=%h exp 0 1 0 0",
                     imem_address, imem_mem_read, imem_mem_write, imem_write_data);
        end
    endtask

    task automatic test_run();
        logic [31:0] exp_ins[3];
        exp_ins[0] = 32'hE000_0000; exp_ins[1] = 32'hE3A0_0014; exp_ins[2] = 32'hE3A0_1A01;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = sb.pop_front();
            n_checks++;
            if (pc_out !== 32'(4 * (i + 1)) || instruction_out !== exp_ins[i] || valid_out !== 1'b1
                || imem_address !== e.pc || fetch_count !== e.count) begin
                n_fail++;
                $display("FAIL run_%0d pc=%h ins=%h v=%b addr=%h cnt=%0d exp pc=%h ins=%h v=1 addr=%h cnt=%0d",
                         i, pc_out, instruction_out, valid_out, imem_address, fetch_count,
                         32'(4 * (i + 1)), exp_ins[i], e.pc, e.count);
            end
        end
        n_checks++;
        if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL run_count got=%0d exp=3", fetch_count); end
    endtask

    task automatic test_freeze();
        tick();
        void'(sb.pop_front());
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = sb.pop_front();
            n_checks++;
            if (imem_address !== 32'd16 || pc_out !== 32'd16 || fetch_count !== 32'd4
                || instruction_out !== e.ifid_instr || valid_out !== 1'b1) begin
                n_fail++;
                $display("FAIL freeze_hold_%0d addr=%h pc=%h cnt=%0d ins=%h v=%b exp addr=10 pc=10 cnt=4 ins=%h v=1",
                         i, imem_address, pc_out, fetch_count, instruction_out, valid_out, e.ifid_instr);
            end
        end
        freeze = 1'b0;
        tick();
        e = sb.pop_front();
        n_checks++;
        if (pc_out !== 32'd20 || instruction_out !== mem_word(32'd16) || valid_out !== 1'b1
            || fetch_count !== 32'd5 || imem_address !== e.pc) begin
            n_fail++;
            $display("FAIL freeze_release pc=%h ins=%h v=%b cnt=%0d addr=%h exp pc=14 ins=%h v=1 cnt=5 addr=%h",
                     pc_out, instruction_out, valid_out, fetch_count, imem_address, mem_word(32'd16), e.pc);
        end
    endtask

    task automatic test_branch();
        freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h0000_0087;
        tick();
        e = sb.pop_front();
        n_checks++;
        if (imem_address !== 32'h84 || valid_out !== 1'b0 || instruction_out !== 32'hE000_0000
            || pc_out !== 32'h0 || fetch_count !== e.count) begin
            n_fail++;
            $display("FAIL branch_redirect addr=%h v=%b ins=%h pc=%h cnt=%0d exp addr=84 v=0 ins=e0000000 pc=0 cnt=%0d",
                     imem_address, valid_out, instruction_out, pc_out, fetch_count, e.count);
        end
        freeze = 1'b0; branch_taken = 1'b0;
        tick();
        e = sb.pop_front();
        n_checks++;
        if (pc_out !== 32'h88 || instruction_out !== mem_word(32'h84) || valid_out !== 1'b1
            || fetch_count !== e.count || imem_address !== e.pc) begin
            n_fail++;
            $display("FAIL branch_target pc=%h ins=%h v=%b cnt=%0d addr=%h exp pc=88 ins=%h v=1 cnt=%0d addr=%h",
                     pc_out, instruction_out, valid_out, fetch_count, imem_address, mem_word(32'h84), e.count, e.pc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgt[2];
        tgt[0] = 32'h40; tgt[1] = 32'h10;
        for (int i = 0; i < 2; i++) begin
            branch_taken = 1'b1; branch_addr = tgt[i];
            tick();
            e = sb.pop_front();
            n_checks++;
            if (imem_address !== tgt[i] || valid_out !== 1'b0 || instruction_out !== 32'hE000_0000
                || fetch_count !== e.count) begin
                n_fail++;
                $display("FAIL b2b_%0d addr=%h v=%b ins=%h cnt=%0d exp addr=%h v=0 ins=e0000000 cnt=%0d",
                         i, imem_address, valid_out, instruction_out, fetch_count, tgt[i], e.count);
            end
        end
        branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sb.pop_front();
            n_checks++;
            if (pc_out !== e.ifid_pc || instruction_out !== e.ifid_instr || valid_out !== e.ifid_valid
                || fetch_count !== e.count || imem_address !== e.pc) begin
                n_fail++;
                $display("FAIL b2b_resume_%0d pc=%h ins=%h v=%b cnt=%0d addr=%h exp %h %h %b %0d %h",
                         i, pc_out, instruction_out, valid_out, fetch_count, imem_address,
                         e.ifid_pc, e.ifid_instr, e.ifid_valid, e.count, e.pc);
            end
        end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFE;
        tick();
        e = sb.pop_front();
        n_checks++;
        if (imem_address !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_redirect addr=%h exp=fffffffc", imem_address);
        end
        branch_taken = 1'b0;
        tick();
        e = sb.pop_front();
        n_checks++;
        if (imem_address !== 32'h0 || pc_out !== 32'h0 || valid_out !== 1'b1
            || instruction_out !== mem_word(32'hFFFF_FFFC) || fetch_count !== e.count) begin
            n_fail++;
            $display("FAIL wrap_step addr=%h pc=%h v=%b ins=%h cnt=%0d exp addr=0 pc=0 v=1 ins=%h cnt=%0d",
                     imem_address, pc_out, valid_out, instruction_out, fetch_count,
                     mem_word(32'hFFFF_FFFC), e.count);
        end
    endtask

    task automatic test_reset_override();
        for (int i = 0; i < 2; i++) begin
            tick(); tick();
            void'(sb.pop_front()); void'(sb.pop_front());
            if (i == 0) begin freeze = 1'b1; end
            else begin branch_taken = 1'b1; branch_addr = 32'h0000_0200; end
            rst = 1'b1;
            #1;
            n_checks++;
            if (imem_mem_read !== 1'b0) begin
                n_fail++; $display("FAIL override_%0d_mem_read got=%b exp=0", i, imem_mem_read);
            end
            tick();
            e = sb.pop_front();
            n_checks++;
            if (imem_address !== 32'h0 || valid_out !== 1'b0 || fetch_count !== 32'h0
                || pc_out !== 32'h0 || instruction_out !== 32'hE000_0000 || e.count !== fetch_count) begin
                n_fail++;
                $display("FAIL override_%0d addr=%h v=%b cnt=%0d pc=%h ins=%h exp addr=0 v=0 cnt=0 pc=0 ins=e0000000",
                         i, imem_address, valid_out, fetch_count, pc_out, instruction_out);
            end
            rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
        end
        tick();
        e = sb.pop_front();
        n_checks++;
        if (pc_out !== 32'h4 || instruction_out !== 32'hE000_0000 || valid_out !== 1'b1 || fetch_count !== 32'd1) begin
            n_fail++;
            $display("FAIL override_restart pc=%h ins=%h v=%b cnt=%0d exp pc=4 ins=e0000000 v=1 cnt=1",
                     pc_out, instruction_out, valid_out, fetch_count);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_freeze();
        test_branch();
        test_back_to_back();
        test_wrap();
        test_reset_override();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
